// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Contents:
//   rx_state_e    receiver FSM state encoding
//   PAR_EVEN/ODD  encodings of the PAR_TYP input
//   MIN_PRESCALE  smallest oversample ratio honoured; smaller Prescale values are clamped
//   par_bit       expected parity bit for a given data XOR and parity type
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned MIN_PRESCALE = 4;

  // Parity bit the transmitter should have sent for data whose bits XOR to data_xor.
  function automatic logic par_bit(input logic data_xor, input logic par_typ);
    logic p;
    p = data_xor;
    case (par_typ)
      PAR_EVEN: p = data_xor;
      PAR_ODD:  p = ~data_xor;
      default:  p = data_xor;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit oversample counter and bit sampler for the UART receiver.
// Build option: UART_RX_MAJORITY_EN selects a 3-sample majority vote (mid-1, mid, mid+1)
// instead of a single sample at mid; the strobe timing is the same in both builds.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rx_in            raw serial line (asynchronous, idle high)
//   run              counter enable; counter is held at 0 while low
//   presc            oversample ticks per bit (already clamped, >= 4)
//   rx_sync          line after the 2-flop synchroniser
//   mid_stb_c        edge counter is at the sample point (presc >> 1)
//   bit_end_c        edge counter is at the last tick of the bit (presc - 1)
//   sampled_bit_c    bit value to use at mid_stb_c
module uart_rx_sampler #(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  rx_sync,
  output logic                  mid_stb_c,
  output logic                  bit_end_c,
  output logic                  sampled_bit_c
);

  logic                  sync1_q;
  logic                  sync2_q;
  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [PRESCALE_W-1:0] edge_cnt_d;
  logic [PRESCALE_W-1:0] mid_pt_c;

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_sync = sync2_q;

  assign mid_pt_c  = presc >> 1;
  assign mid_stb_c = (edge_cnt_q == mid_pt_c);
  assign bit_end_c = (edge_cnt_q == (presc - PRESCALE_W'(1)));

  // Edge counter: 0..presc-1 per bit while the FSM is busy, 0 otherwise.
  always_comb begin
    edge_cnt_d = '0;
    if (run) begin
      edge_cnt_d = bit_end_c ? '0 : edge_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= sync2_q;
    end
  end

  // sync1_q already holds the value the FSM will see next cycle, so the mid+1 sample is
  // available at mid without delaying the strobe.
  assign sampled_bit_c = (rx_prev_q & sync2_q) | (rx_prev_q & sync1_q) | (sync2_q & sync1_q);
`else
  assign sampled_bit_c = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled deframing of start/data/parity/stop with a
// one-entry valid/ready output register, per-frame error flags and overrun pulse.
// Build option: UART_RX_MAJORITY_EN (see uart_rx_sampler) enables majority-vote sampling.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   RX_IN           serial line, idle high, asynchronous to CLK
//   Prescale        oversample ticks per bit (values below 4 act as 4)
//   PAR_EN/PAR_TYP  parity present / 0 even, 1 odd
//   STOP2           two stop bits expected
//   Data_Ready      consumer accepts the held frame this cycle
//   P_DATA          received data word
//   Data_Valid      output register holds an unconsumed frame
//   Parity_Error    held frame's parity mismatched
//   Stop_Error      a stop bit of the held frame sampled 0
//   Overrun_Error   one-cycle pulse when a completed frame is dropped
//   Busy            receiver FSM is not idle
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  Data_Ready,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Overrun_Error,
  output logic                  Busy
);

  localparam int unsigned BCNT_W = $clog2(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;

  logic                  rx_sync;
  logic                  mid_stb_c;
  logic                  bit_end_c;
  logic                  sampled_bit_c;
  logic                  commit_c;
  logic [PRESCALE_W-1:0] presc_eff_c;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk           (CLK),
    .rst           (RST),
    .rx_in         (RX_IN),
    .run           (state_q != IDLE),
    .presc         (presc_q),
    .rx_sync       (rx_sync),
    .mid_stb_c     (mid_stb_c),
    .bit_end_c     (bit_end_c),
    .sampled_bit_c (sampled_bit_c)
  );

  assign presc_eff_c = (Prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE)
                                                              : Prescale;

  // Deframing FSM and output register next-state.
  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    stop2_d        = stop2_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    stop_err_d     = stop_err_q;
    p_data_d       = p_data_q;
    data_valid_d   = data_valid_q;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    overrun_d      = 1'b0;
    commit_c       = 1'b0;

    case (state_q)
      IDLE: begin
        // Frame configuration is frozen here for the whole frame.
        if (!rx_sync) begin
          state_d    = START;
          presc_d    = presc_eff_c;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          stop2_d    = STOP2;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      START: begin
        if (mid_stb_c && sampled_bit_c) begin
          state_d = IDLE;
        end else if (bit_end_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mid_stb_c) begin
          shift_d = {sampled_bit_c, shift_q[DATA_WIDTH-1:1]};
        end
        if (bit_end_c) begin
          if (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (mid_stb_c) begin
          par_err_d = (sampled_bit_c != par_bit(^shift_q, par_typ_q));
        end
        if (bit_end_c) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (mid_stb_c) begin
          if (!sampled_bit_c) begin
            stop_err_d = 1'b1;
          end
          // Commit at the mid sample of the last stop bit so a following start edge is caught.
          if (!stop2_q || (bit_cnt_q == BCNT_W'(1))) begin
            commit_c = 1'b1;
            state_d  = IDLE;
          end
        end
        if (bit_end_c) begin
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // One-entry output register; a commit into a full, unconsumed register is dropped.
    if (commit_c) begin
      if (!data_valid_q || Data_Ready) begin
        p_data_d       = shift_q;
        parity_error_d = par_err_q;
        stop_error_d   = stop_err_d;
        data_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && Data_Ready) begin
      data_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      presc_q        <= PRESCALE_W'(MIN_PRESCALE);
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      stop2_q        <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      stop2_q        <= stop2_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_err_q      <= par_err_d;
      stop_err_q     <= stop_err_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
    end
  end

  assign P_DATA        = p_data_q;
  assign Data_Valid    = data_valid_q;
  assign Parity_Error  = parity_error_q;
  assign Stop_Error    = stop_error_q;
  assign Overrun_Error = overrun_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: directed frames push expected words into per-DUT
// queues; negedge monitors pop and compare on every output handshake.
module tb_uart_rx_param;

  localparam int unsigned PW = 6;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST;
  logic          rx8, rx5;
  logic [PW-1:0] presc;
  logic          pen, ptyp, stop2, rdy8, rdy5;

  logic [7:0] pd8;
  logic       dv8, pe8, se8, ov8, bz8;
  logic [4:0] pd5;
  logic       dv5, pe5, se5, ov5, bz5;

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(PW)) u_dut8 (
    .CLK(CLK), .RST(RST), .RX_IN(rx8), .Prescale(presc), .PAR_EN(pen), .PAR_TYP(ptyp),
    .STOP2(stop2), .Data_Ready(rdy8), .P_DATA(pd8), .Data_Valid(dv8), .Parity_Error(pe8),
    .Stop_Error(se8), .Overrun_Error(ov8), .Busy(bz8)
  );

  uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_W(PW)) u_dut5 (
    .CLK(CLK), .RST(RST), .RX_IN(rx5), .Prescale(presc), .PAR_EN(pen), .PAR_TYP(ptyp),
    .STOP2(stop2), .Data_Ready(rdy5), .P_DATA(pd5), .Data_Valid(dv5), .Parity_Error(pe5),
    .Stop_Error(se5), .Overrun_Error(ov5), .Busy(bz5)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8, e5;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_ovr8 = 0;
  int   n_ovr5 = 0;
  bit   hs8_prev = 1'b0;
  bit   hs5_prev = 1'b0;
  bit   busy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect8(input logic [8:0] d, input logic p, input logic s);
    q8.push_back(exp_t'{data: d, perr: p, serr: s});
  endtask

  task automatic expect5(input logic [8:0] d, input logic p, input logic s);
    q5.push_back(exp_t'{data: d, perr: p, serr: s});
  endtask

  // Drive one frame, bitlen cycles per bit. glitch_at forces the line low for that one
  // cycle; cut_at >= 0 abandons the frame (line back high) after that many cycles.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int bitlen, input bit pe, input bit pt, input bit pflip,
                            input int nstop, input bit last_stop, input int glitch_at,
                            input int cut_at);
    logic [15:0] fb;
    int          nb;
    int          c;
    logic        par;
    logic        v;
    fb  = '0;
    nb  = 1;
    par = pt;
    for (int i = 0; i < nbits; i++) begin
      fb[nb] = data[i];
      par    = par ^ data[i];
      nb++;
    end
    if (pe) begin
      fb[nb] = par ^ pflip;
      nb++;
    end
    for (int i = 0; i < nstop; i++) begin
      fb[nb] = (i == nstop - 1) ? last_stop : 1'b1;
      nb++;
    end
    c = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < bitlen; k++) begin
        if (cut_at >= 0 && c >= cut_at) begin
          if (which == 0) rx8 = 1'b1; else rx5 = 1'b1;
          return;
        end
        v = (c == glitch_at) ? 1'b0 : fb[b];
        if (which == 0) rx8 = v; else rx5 = v;
        tick();
        c++;
      end
    end
    if (which == 0) rx8 = 1'b1; else rx5 = 1'b1;
  endtask

  // Monitor for the 8-bit receiver.
  always @(negedge CLK) begin
    if (RST) begin
      hs8_prev <= 1'b0;
    end else begin
      if (ov8) n_ovr8 <= n_ovr8 + 1;
      if (hs8_prev) check("dv_clear8", 32'(dv8), 32'd0);
      hs8_prev <= dv8 && rdy8;
      if (dv8 && rdy8) begin
        check("frame_pending8", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          check("p_data8", 32'(pd8), 32'(e8.data));
          check("parity_err8", 32'(pe8), 32'(e8.perr));
          check("stop_err8", 32'(se8), 32'(e8.serr));
        end
      end
    end
  end

  // Monitor for the 5-bit receiver.
  always @(negedge CLK) begin
    if (RST) begin
      hs5_prev <= 1'b0;
    end else begin
      if (ov5) n_ovr5 <= n_ovr5 + 1;
      if (hs5_prev) check("dv_clear5", 32'(dv5), 32'd0);
      hs5_prev <= dv5 && rdy5;
      if (dv5 && rdy5) begin
        check("frame_pending5", 32'(q5.size() != 0), 32'd1);
        if (q5.size() != 0) begin
          e5 = q5.pop_front();
          check("p_data5", 32'(pd5), 32'(e5.data));
          check("parity_err5", 32'(pe5), 32'(e5.perr));
          check("stop_err5", 32'(se5), 32'(e5.serr));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    RST = 1'b1; rx8 = 1'b1; rx5 = 1'b1; presc = PW'(8);
    pen = 1'b1; ptyp = 1'b0; stop2 = 1'b0; rdy8 = 1'b1; rdy5 = 1'b1;
    repeat (3) tick();
    check("rst_p_data", 32'(pd8), 32'd0);
    check("rst_valid", 32'(dv8), 32'd0);
    check("rst_perr", 32'(pe8), 32'd0);
    check("rst_serr", 32'(se8), 32'd0);
    check("rst_ovr", 32'(ov8), 32'd0);
    check("rst_busy", 32'(bz8), 32'd0);
    check("rst_valid5", 32'(dv5), 32'd0);
    check("rst_busy5", 32'(bz5), 32'd0);
    RST = 1'b0;
    repeat (5) tick();

    // Even parity, clean frame.
    expect8(9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, 8, 1, 0, 0, 1, 1'b1, -1, -1);
    repeat (16) tick();
    // Wrong parity bit.
    expect8(9'h0A5, 1'b1, 1'b0);
    send_frame(0, 9'h0A5, 8, 8, 1, 0, 1, 1, 1'b1, -1, -1);
    repeat (16) tick();
    // Stop bit low; the tail of the low stop bit is rejected as a false start.
    expect8(9'h0A5, 1'b0, 1'b1);
    send_frame(0, 9'h0A5, 8, 8, 1, 0, 0, 1, 1'b0, -1, -1);
    repeat (24) tick();
    // Odd parity.
    ptyp = 1'b1;
    expect8(9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 8, 1, 1, 0, 1, 1'b1, -1, -1);
    repeat (16) tick();
    ptyp = 1'b0;
    // No parity bit.
    pen = 1'b0;
    expect8(9'h080, 1'b0, 1'b0);
    send_frame(0, 9'h080, 8, 8, 0, 0, 0, 1, 1'b1, -1, -1);
    repeat (16) tick();
    pen = 1'b1;
    // Prescale below the minimum behaves as 4.
    presc = PW'(2);
    expect8(9'h05A, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 4, 1, 0, 0, 1, 1'b1, -1, -1);
    repeat (16) tick();
    presc = PW'(8);
    // Configuration changes mid-frame must not affect the frame in flight.
    expect8(9'h0C3, 1'b0, 1'b0);
    fork
      send_frame(0, 9'h0C3, 8, 8, 1, 0, 0, 1, 1'b1, -1, -1);
      begin
        repeat (12) tick();
        presc = PW'(13); pen = 1'b0; ptyp = 1'b1;
      end
    join
    presc = PW'(8); pen = 1'b1; ptyp = 1'b0;
    repeat (16) tick();

    // Two-tick low pulse: start rejected, Busy pulses, nothing delivered.
    rx8 = 1'b0;
    tick();
    tick();
    rx8 = 1'b1;
    busy_seen = 1'b0;
    repeat (20) begin
      tick();
      if (bz8) busy_seen = 1'b1;
    end
    check("glitch_busy_pulse", 32'(busy_seen), 32'd1);
    check("glitch_busy_idle", 32'(bz8), 32'd0);
    check("glitch_no_valid", 32'(dv8), 32'd0);
    check("glitch_no_perr", 32'(pe8), 32'd0);

    // Overrun: consumer stalled, two back-to-back frames.
    rdy8 = 1'b0;
    expect8(9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 8, 1, 0, 0, 1, 1'b1, -1, -1);
    send_frame(0, 9'h022, 8, 8, 1, 0, 0, 1, 1'b1, -1, -1);
    repeat (6) tick();
    check("ovr_hold_valid", 32'(dv8), 32'd1);
    check("ovr_hold_data", 32'(pd8), 32'h11);
    check("ovr_pulse_count", 32'(n_ovr8), 32'd1);
    rdy8 = 1'b1;
    repeat (8) tick();

    // 5-bit receiver, two stop bits, no parity.
    stop2 = 1'b1; pen = 1'b0;
    expect5(9'h01F, 1'b0, 1'b0);
    send_frame(1, 9'h01F, 5, 8, 0, 0, 0, 2, 1'b1, -1, -1);
    repeat (12) tick();
    expect5(9'h00A, 1'b0, 1'b1);
    send_frame(1, 9'h00A, 5, 8, 0, 0, 0, 2, 1'b0, -1, -1);
    repeat (24) tick();
    stop2 = 1'b0; pen = 1'b1;

    // One-cycle low glitch at the sample point of data bit 3 (line cycle 8*4+5).
`ifdef UART_RX_MAJORITY_EN
    expect8(9'h0FF, 1'b0, 1'b0);
`else
    expect8(9'h0F7, 1'b1, 1'b0);
`endif
    send_frame(0, 9'h0FF, 8, 8, 1, 0, 0, 1, 1'b1, 37, -1);
    repeat (16) tick();

    // Reset in the middle of the data bits.
    send_frame(0, 9'h03C, 8, 8, 1, 0, 0, 1, 1'b1, -1, 40);
    check("pre_rst_busy", 32'(bz8), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_p_data", 32'(pd8), 32'd0);
    check("mid_rst_valid", 32'(dv8), 32'd0);
    check("mid_rst_busy", 32'(bz8), 32'd0);
    repeat (2) tick();
    RST = 1'b0;
    repeat (10) tick();
    expect8(9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 8, 1, 0, 0, 1, 1'b1, -1, -1);
    repeat (20) tick();

    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q5_drained", 32'(q5.size()), 32'd0);
    check("ovr8_total", 32'(n_ovr8), 32'd1);
    check("ovr5_total", 32'(n_ovr5), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
